instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Upstream fetch stage for the MIPS core.
- Replaces the ideal combinational instruction memory with a handshaked interface to a multi-cycle instruction memory.
- Holds a small in-order prefetch queue and presents one instruction per cycle to decode/control with valid/ready.
- Accepts branch/jump redirects from the datapath and flushes stale fetches.

Parameters:
QUEUE_DEPTH, 4, prefetch queue entries; power of two, 2..16; also the maximum number of outstanding memory requests.
RESET_PC, 32'h0000_0000, PC of the first fetch after reset.

Ports:
clk  in  1  clock
rst  in  1  reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts the request this cycle
imem_req_addr  out  32  word-aligned fetch address
imem_rsp_valid  in  1  response valid; responses return in request order, at least 1 cycle after acceptance
imem_rsp_data  in  32  fetched instruction
redirect_valid  in  1  one-cycle pulse: taken branch or jump
redirect_pc  in  32  new fetch target; bits [1:0] ignored
instr_valid  out  1  instr/instr_pc are valid
instr_ready  in  1  consumer takes the instruction this cycle
instr  out  32  instruction word
instr_pc  out  32  address of instr
instr_pc_plus4  out  32  instr_pc + 4, for branch target computation

Behaviour:
- Reset: clk is the single clock; rst is asynchronous, active-high. While rst is high:
  - fetch_pc = RESET_PC; queue empty; outstanding = 0; drop = 0; state = RUN.
  - imem_req_valid = 0, instr_valid = 0, instr/instr_pc/instr_pc_plus4 = 0.
- Reset mid-operation aborts everything in flight. The memory must ignore responses owed to pre-reset requests; the IFU does not count them.
- State RUN:
  - imem_req_valid = 1 when (count + outstanding) < QUEUE_DEPTH.
  - imem_req_addr = {fetch_pc[31:2], 2'b00}.
  - On req handshake: fetch_pc += 4 (mod 2^32, wraps to 0) and outstanding++.
  - On rsp_valid: push {data, pc}; outstanding--. The pc comes from a parallel PC queue written at request time.
- Output: instr_valid = queue not empty; head is shown. On valid & ready the head pops. This gives one instruction per cycle when the queue is non-empty.
- Latency: with a 1-cycle memory, first instr_valid appears 2 cycles after rst deasserts (request cycle, then response cycle, then queue output).
- Space rule: a response can never find the queue full, because space is reserved at request time.
- Simultaneous push and pop on a full queue is legal.
- Redirect (any state):
  - Queue flushed, so instr_valid = 0 next cycle.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - drop += outstanding, minus 1 if a response arrives this same cycle (that response is discarded).
  - A request handshaking in the redirect cycle also counts toward drop.
  - Pop in the redirect cycle is still honoured.
  - Next state = FLUSH if the resulting drop > 0, else RUN.
- State FLUSH:
  - imem_req_valid = 0.
  - Each rsp_valid decrements drop and the data is discarded.
  - When drop hits 0, go to RUN; the first new request issues in that next cycle.
- Redirect during FLUSH: fetch_pc is updated and drop is recomputed per the rule above.
- imem_req_addr must be held stable while imem_req_valid = 1 and imem_req_ready = 0, unless a redirect occurs.

Optional Feature:
IFU_PERF_CNT_EN
- Defined: adds outputs perf_fetch_stall (32-bit) and perf_flush_cnt (32-bit). Both are cleared by rst and saturate at all-ones.
  - perf_fetch_stall counts cycles where instr_ready = 1 and instr_valid = 0.
  - perf_flush_cnt counts redirect pulses.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared package mips_pkg holds:
  - WORD_W = 32 and the PC increment constant 4.
  - ifu_state_t enum {RUN, FLUSH}.
  - Queue entry struct {instr, pc}.
- One sub-module, ifu_queue: a synchronous FIFO (QUEUE_DEPTH x 64 bits) with push, pop, flush, count, empty and full. Flush has priority over push in the same cycle.

Test Plan:
1. Reset release with a 1-cycle, always-ready memory and instr_ready = 1 -> instr_pc sequence 0x0, 0x4, 0x8, ... one per cycle after the initial 2-cycle latency; instr_pc_plus4 = instr_pc + 4.
2. instr_ready held 0 for 10 cycles -> exactly QUEUE_DEPTH = 4 requests issued, then imem_req_valid = 0. Release -> 4 buffered instructions pop back-to-back in order, with no drop or duplicate.
3. Memory latency 3 with 3 requests outstanding, then redirect to 0x100 -> state FLUSH, 3 responses discarded, next request address 0x100, first delivered instr_pc = 0x100.
4. Redirect to 0x203 while idle with nothing outstanding -> stays RUN, next request 0x200 issued the following cycle.
5. fetch_pc = 0xFFFF_FFFC -> next request address 0x0000_0000 (wrap).
6. rst asserted asynchronously mid-burst, not on a clock edge -> all outputs go to 0 immediately; after release, fetch restarts at RESET_PC with no stale instructions delivered.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS front end (fetch unit and its queue).
package mips_pkg;

  localparam int WORD_W = 32;
  localparam logic [WORD_W-1:0] PC_INC = 32'd4;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } ifu_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] instr;
    logic [WORD_W-1:0] pc;
  } ifu_entry_t;

endpackage

// File: rtl/ifu_queue.sv
// In-order prefetch FIFO of {instr, pc} entries; flush wins over push in the same cycle.
module ifu_queue
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  ifu_entry_t             push_data,
  input  logic                   pop,
  input  logic                   flush,
  output ifu_entry_t             head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W + 1)'(DEPTH);

  ifu_entry_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_FULL);
  assign do_pop  = pop && !empty;
  // A pop frees the slot this cycle, so push into a full queue is fine alongside it.
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues requests to a multi-cycle imem, buffers responses, handles redirects.
// Optional IFU_PERF_CNT_EN adds stall/flush performance counters.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus4
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_stall,
  output logic [31:0] perf_flush_cnt
`endif
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(QUEUE_DEPTH);

  ifu_state_t        state;
  logic [WORD_W-1:0] fetch_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop;
  logic [CNT_W-1:0]  drop_next;
  logic [CNT_W-1:0]  count;
  logic [CNT_W:0]    inflight;
  logic [WORD_W-1:0] pcq [QUEUE_DEPTH];
  logic [PTR_W-1:0]  pcq_wr;
  logic [PTR_W-1:0]  pcq_rd;
  logic              req_fire;
  logic              rsp_take;
  logic              empty;
  logic              full;
  ifu_entry_t        head;
  ifu_entry_t        push_data;
  logic              unused_ok;

  assign unused_ok = &{1'b0, redirect_pc[1:0]};

  // Queue slots are reserved at request time, so a response always finds room.
  assign inflight       = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && (state == RUN) && !full && (inflight < DEPTH_W);
  assign imem_req_addr  = {fetch_pc[31:2], 2'b00};
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_take       = imem_rsp_valid && (state == RUN) && !redirect_valid;
  assign push_data      = {imem_rsp_data, pcq[pcq_rd]};

  // Everything still owed by memory at a redirect becomes a response to discard.
  always_comb begin
    drop_next = drop + outstanding;
    if (req_fire) drop_next = drop_next + CNT_ONE;
    if (imem_rsp_valid && (drop_next != '0)) drop_next = drop_next - CNT_ONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= RUN;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else if (redirect_valid) begin
      state       <= (drop_next != '0) ? FLUSH : RUN;
      fetch_pc    <= {redirect_pc[31:2], 2'b00};
      outstanding <= '0;
      drop        <= drop_next;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
    end else begin
      case (state)
        RUN: begin
          if (req_fire) begin
            fetch_pc <= fetch_pc + PC_INC;
            pcq_wr   <= pcq_wr + PTR_ONE;
          end
          if (rsp_take) pcq_rd <= pcq_rd + PTR_ONE;
          case ({req_fire, rsp_take})
            2'b10:   outstanding <= outstanding + CNT_ONE;
            2'b01:   outstanding <= outstanding - CNT_ONE;
            default: outstanding <= outstanding;
          endcase
        end
        FLUSH: begin
          if (imem_rsp_valid) begin
            drop <= drop - CNT_ONE;
            if (drop == CNT_ONE) state <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

  // PC of each request, read back in order when its response returns.
  always_ff @(posedge clk) begin
    if (req_fire && !redirect_valid) pcq[pcq_wr] <= fetch_pc;
  end

  ifu_queue #(
    .DEPTH(QUEUE_DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (rsp_take),
    .push_data (push_data),
    .pop       (instr_ready),
    .flush     (redirect_valid),
    .head      (head),
    .count     (count),
    .empty     (empty),
    .full      (full)
  );

  assign instr_valid    = !empty;
  assign instr          = empty ? '0 : head.instr;
  assign instr_pc       = empty ? '0 : head.pc;
  assign instr_pc_plus4 = empty ? '0 : head.pc + PC_INC;

`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_fetch_stall <= '0;
      perf_flush_cnt   <= '0;
    end else begin
      if (instr_ready && !instr_valid && (perf_fetch_stall != '1))
        perf_fetch_stall <= perf_fetch_stall + 32'd1;
      if (redirect_valid && (perf_flush_cnt != '1))
        perf_flush_cnt <= perf_flush_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Table-driven bench for instr_fetch_unit with a behavioural multi-cycle instruction memory.
module tb_instr_fetch_unit;
  import mips_pkg::*;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus4;

  instr_fetch_unit #(
    .QUEUE_DEPTH(4),
    .RESET_PC   (32'h0000_0000)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pc_plus4 (instr_pc_plus4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1);
  end

  // ---------------- memory model ----------------
  int          cyc;
  int          mem_lat;
  logic        mem_ready;
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_0F1E;
  endfunction

  initial begin
    int due;
    cyc = 0;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      cyc++;
      imem_req_ready = mem_ready;
      if (rst) begin
        pend_addr.delete();
        pend_due.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end else begin
        if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
          imem_rsp_valid = 1'b1;
          imem_rsp_data  = mem_word(pend_addr.pop_front());
          due = pend_due.pop_front();
        end else begin
          imem_rsp_valid = 1'b0;
          imem_rsp_data  = '0;
        end
        if (imem_req_valid && imem_req_ready) begin
          pend_addr.push_back(imem_req_addr);
          pend_due.push_back(cyc + mem_lat);
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  int          tests_run;
  int          tests_failed;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit          rst_before;
    int          lat;
    bit          rdy;
    bit          mrdy;
    bit          redir;
    logic [31:0] rpc;
    bit          exp_req;
    logic [31:0] exp_addr;
    bit          exp_valid;
    logic [31:0] exp_pc;
    ifu_state_t  exp_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit rb, int lat, bit rdy, bit mrdy, bit redir, logic [31:0] rpc,
                              bit er, logic [31:0] ea, bit ev, logic [31:0] epc, ifu_state_t st);
    vec_t v;
    v.rst_before = rb;  v.lat = lat;     v.rdy = rdy;      v.mrdy = mrdy;
    v.redir = redir;    v.rpc = rpc;     v.exp_req = er;   v.exp_addr = ea;
    v.exp_valid = ev;   v.exp_pc = epc;  v.exp_st = st;
    return v;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic apply_vec(input int idx);
    vec_t v;
    v = vecs[idx];
    if (v.rst_before) begin
      rst = 1'b1;
      mem_lat = v.lat;
      repeat (2) @(negedge clk);
    end
    @(negedge clk);
    rst            = 1'b0;
    instr_ready    = v.rdy;
    mem_ready      = v.mrdy;
    redirect_valid = v.redir;
    redirect_pc    = v.rpc;
    #2;
    check($sformatf("v%0d req_valid", idx), {31'd0, imem_req_valid}, {31'd0, v.exp_req});
    if (v.exp_req)
      check($sformatf("v%0d req_addr", idx), imem_req_addr, v.exp_addr);
    check($sformatf("v%0d instr_valid", idx), {31'd0, instr_valid}, {31'd0, v.exp_valid});
    if (v.exp_valid) begin
      check($sformatf("v%0d instr_pc", idx), instr_pc, v.exp_pc);
      check($sformatf("v%0d instr", idx), instr, mem_word(v.exp_pc));
      check($sformatf("v%0d pc_plus4", idx), instr_pc_plus4, v.exp_pc + 32'd4);
    end
    check($sformatf("v%0d state", idx), 32'(dut.state), 32'(v.exp_st));
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) apply_vec(i);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " req_valid"}, {31'd0, imem_req_valid}, 32'd0);
    check({tag, " instr_valid"}, {31'd0, instr_valid}, 32'd0);
    check({tag, " instr"}, instr, 32'd0);
    check({tag, " instr_pc"}, instr_pc, 32'd0);
    check({tag, " pc_plus4"}, instr_pc_plus4, 32'd0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int t1_lo, t2_lo, t4_lo, t3_lo, t5_lo, t5_hi;
    logic [31:0] e;
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    mem_ready = 1'b1;
    mem_lat = 1;

    // 1: streaming with a 1-cycle memory, pc 0,4,8.. after 2-cycle latency
    t1_lo = vecs.size();
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(k == 0, 1, 1'b1, 1'b1, 1'b0, 32'd0,
                        1'b1, 32'(4 * k), k >= 2, 32'(4 * (k - 2)), RUN));
    // 2: consumer stalls 10 cycles -> exactly 4 requests, then back-to-back drain
    t2_lo = vecs.size();
    for (int k = 0; k < 16; k++)
      vecs.push_back(mk(k == 0, 1, k >= 10, 1'b1, 1'b0, 32'd0,
                        (k < 4) || (k >= 11), (k < 4) ? 32'(4 * k) : 32'(16 + 4 * (k - 11)),
                        k >= 2, (k <= 10) ? 32'd0 : 32'(4 * (k - 10)), RUN));
    // 4: redirect to 0x203 with a full queue and nothing outstanding
    t4_lo = vecs.size();
    for (int k = 0; k < 10; k++)
      vecs.push_back(mk(k == 0, 1, 1'b0, 1'b1, k == 6, 32'h0000_0203,
                        (k < 4) || (k >= 7), (k < 4) ? 32'(4 * k) : 32'(32'h200 + 4 * (k - 7)),
                        ((k >= 2) && (k <= 6)) || (k == 9), (k == 9) ? 32'h200 : 32'd0, RUN));
    // 3: 3-cycle memory, redirect to 0x100 with 3 requests in flight
    t3_lo = vecs.size();
    for (int k = 0; k < 14; k++)
      vecs.push_back(mk(k == 0, 3, 1'b1, 1'b1, k == 2, 32'h0000_0100,
                        (k <= 2) || ((k >= 6) && (k <= 9)) || (k >= 11),
                        (k <= 2) ? 32'(4 * k) : (k <= 9) ? 32'(32'h100 + 4 * (k - 6))
                                                         : 32'(32'h110 + 4 * (k - 11)),
                        k >= 10, 32'(32'h100 + 4 * (k - 10)),
                        ((k >= 3) && (k <= 5)) ? FLUSH : RUN));
    // 5: address held while memory stalls, then wrap from 0xFFFF_FFFC to 0
    t5_lo = vecs.size();
    for (int k = 0; k < 7; k++)
      vecs.push_back(mk(k == 0, 1, 1'b1, k >= 3, k == 1, 32'hFFFF_FFFC,
                        1'b1, (k <= 1) ? 32'd0 : (k <= 3) ? 32'hFFFF_FFFC : 32'(4 * (k - 4)),
                        k >= 5, (k == 5) ? 32'hFFFF_FFFC : 32'd0, RUN));
    t5_hi = vecs.size() - 1;

    repeat (3) @(negedge clk);
    #2;
    check_outputs_zero("reset");
    check("reset state", 32'(dut.state), 32'(RUN));

    run_range(t1_lo, t2_lo - 1);
    run_range(t2_lo, t4_lo - 1);
    run_range(t4_lo, t3_lo - 1);
    run_range(t3_lo, t5_lo - 1);
    run_range(t5_lo, t5_hi);

    // 6: asynchronous reset in the middle of a burst, away from any clock edge
    run_range(t1_lo, t1_lo + 4);
    check("pre_async instr_valid", {31'd0, instr_valid}, 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check_outputs_zero("async_rst");
    repeat (2) @(negedge clk);
    mem_lat = 1;
    exp_q = {32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) begin
      @(negedge clk);
      rst = 1'b0;
      instr_ready = 1'b1;
      mem_ready = 1'b1;
      redirect_valid = 1'b0;
      #2;
      if (instr_valid) begin
        e = exp_q.pop_front();
        check($sformatf("post_rst pc #%0d", c), instr_pc, e);
        check($sformatf("post_rst instr #%0d", c), instr, mem_word(e));
      end
    end
    check("post_rst drain left", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
